// File: rtl/psum_acc_pkg.sv
// Shared types, default widths and the requantization helper for psum_accumulator.
package psum_acc_pkg;

    localparam int unsigned DEF_LANES      = 4;
    localparam int unsigned DEF_IN_W       = 20;
    localparam int unsigned DEF_ACC_W      = 32;
    localparam int unsigned DEF_OUT_W      = 8;
    localparam int unsigned DEF_FIFO_DEPTH = 4;
    localparam int unsigned CNT_W          = 8;
    localparam int unsigned SHIFT_W        = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Job configuration captured at cfg_start.
    typedef struct packed {
        logic [CNT_W-1:0]     rounds;
        logic [CNT_W-1:0]     tiles;
        logic [SHIFT_W-1:0]   shift;
        logic                 relu;
        logic [DEF_ACC_W-1:0] bias;
    } cfg_t;

    localparam logic signed [DEF_ACC_W-1:0] SAT_MAX = DEF_ACC_W'((2 ** (DEF_OUT_W - 1)) - 1);
    localparam logic signed [DEF_ACC_W-1:0] SAT_MIN = DEF_ACC_W'(-(2 ** (DEF_OUT_W - 1)));

    // Floor shift, optional ReLU, then saturate to the signed output range.
    function automatic logic [DEF_OUT_W-1:0] sat_relu(
        input logic signed [DEF_ACC_W-1:0] acc,
        input logic        [SHIFT_W-1:0]   shift,
        input logic                        relu
    );
        logic signed [DEF_ACC_W-1:0] v;
        v = acc >>> shift;
        if (relu && (v < 0)) begin
            v = '0;
        end
        if (v > SAT_MAX) begin
            v = SAT_MAX;
        end else if (v < SAT_MIN) begin
            v = SAT_MIN;
        end
        return v[DEF_OUT_W-1:0];
    endfunction

endpackage

// File: rtl/psum_accumulator_fifo.sv
// Synchronous non-fall-through tile FIFO.
// Ports: push/push_data write side; out_valid/out_data/out_ready read side; count = occupancy.
module psum_fifo #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [W-1:0]               out_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_c;
    logic          pop_c;

    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign pop_c     = out_valid && out_ready;
    // A write into a full FIFO is dropped; the upstream reservation keeps this unreachable.
    assign push_c    = push && (count != CW'(DEPTH));

    // Storage and pointers; memory is cleared so out_data reads zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push_c, pop_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/psum_accumulator.sv
// Partial-sum accumulator: sums cfg_rounds beats per tile, adds bias, requantizes and
// queues finished tiles in an output FIFO.
// Ports: cfg_* job setup (latched on cfg_start in IDLE); res_valid/res/res_ready input
// beats; out_valid/out_data/out_ready tile stream; busy while a job runs; job_done pulse.
module psum_accumulator
    import psum_acc_pkg::*;
#(
    parameter int unsigned LANES      = DEF_LANES,
    parameter int unsigned IN_W       = DEF_IN_W,
    parameter int unsigned ACC_W      = DEF_ACC_W,
    parameter int unsigned OUT_W      = DEF_OUT_W,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_start,
    input  logic [7:0]               cfg_rounds,
    input  logic [7:0]               cfg_tiles,
    input  logic [4:0]               cfg_shift,
    input  logic                     cfg_relu,
    input  logic [ACC_W-1:0]         cfg_bias,
    input  logic                     res_valid,
    input  logic [LANES*IN_W-1:0]    res,
    output logic                     res_ready,
    output logic                     out_valid,
    output logic [LANES*OUT_W-1:0]   out_data,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     job_done
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    state_t                   state;
    state_t                   next_state;
    cfg_t                     cfg_q;
    logic [7:0]               rnd_cnt;
    logic [7:0]               tile_cnt;
    logic [LANES*ACC_W-1:0]   acc_q;
    logic [LANES*ACC_W-1:0]   sum_c;
    logic [LANES*OUT_W-1:0]   post_c;
    logic [LANES*OUT_W-1:0]   post_data;
    logic                     post_pending;
    logic [CW-1:0]            fifo_count;
    logic                     beat_c;
    logic                     rnd_last_c;
    logic                     tile_last_c;
    logic                     tile_done_c;

    // The tile sitting in the post register already owns a FIFO slot.
    assign res_ready   = (state == ACC) &&
                         (({1'b0, fifo_count} + (CW+1)'(post_pending)) < (CW+1)'(FIFO_DEPTH));
    assign beat_c      = res_valid && res_ready;
    assign rnd_last_c  = (rnd_cnt == (cfg_q.rounds - 8'd1));
    assign tile_last_c = (tile_cnt == (cfg_q.tiles - 8'd1));
    assign tile_done_c = beat_c && rnd_last_c;

    // Per-lane sum: the first beat of a tile starts from bias instead of the old accumulator.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [ACC_W-1:0] ext_c;
        logic [ACC_W-1:0] base_c;
        assign ext_c  = ACC_W'($signed(res[l*IN_W +: IN_W]));
        assign base_c = (rnd_cnt == 8'd0) ? cfg_q.bias : acc_q[l*ACC_W +: ACC_W];
        assign sum_c[l*ACC_W +: ACC_W]  = base_c + ext_c;
        assign post_c[l*OUT_W +: OUT_W] = sat_relu(sum_c[l*ACC_W +: ACC_W], cfg_q.shift, cfg_q.relu);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (cfg_start) next_state = ACC;
            ACC:     if (tile_done_c && tile_last_c) next_state = DRAIN;
            DRAIN:   if (post_pending) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Config capture and round/tile counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q    <= '0;
            rnd_cnt  <= '0;
            tile_cnt <= '0;
        end else if ((state == IDLE) && cfg_start) begin
            cfg_q.rounds <= (cfg_rounds == 8'd0) ? 8'd1 : cfg_rounds;
            cfg_q.tiles  <= (cfg_tiles == 8'd0) ? 8'd1 : cfg_tiles;
            cfg_q.shift  <= cfg_shift;
            cfg_q.relu   <= cfg_relu;
            cfg_q.bias   <= cfg_bias;
            rnd_cnt      <= '0;
            tile_cnt     <= '0;
        end else if (beat_c) begin
            if (rnd_last_c) begin
                rnd_cnt  <= '0;
                tile_cnt <= tile_cnt + 8'd1;
            end else begin
                rnd_cnt  <= rnd_cnt + 8'd1;
            end
        end
    end

    // Lane accumulators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (beat_c) begin
            acc_q <= sum_c;
        end
    end

    // Post register: holds a finished tile for exactly one cycle before the FIFO write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_pending <= 1'b0;
            post_data    <= '0;
        end else begin
            post_pending <= tile_done_c;
            if (tile_done_c) begin
                post_data <= post_c;
            end
        end
    end

    // Status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            job_done <= 1'b0;
        end else begin
            busy     <= (next_state != IDLE);
            job_done <= (state == DRAIN) && post_pending;
        end
    end

    psum_fifo #(
        .W     (LANES*OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (post_pending),
        .push_data (post_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_psum_accumulator.sv
// Scoreboard bench for psum_accumulator: stimulus pushes expected tiles, a monitor pops
// and compares each tile the DUT hands out.
module tb_psum_accumulator;

    localparam int unsigned LANES = 4;
    localparam int unsigned IN_W  = 20;
    localparam int unsigned ACC_W = 32;
    localparam int unsigned OUT_W = 8;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   cfg_start;
    logic [7:0]             cfg_rounds;
    logic [7:0]             cfg_tiles;
    logic [4:0]             cfg_shift;
    logic                   cfg_relu;
    logic [ACC_W-1:0]       cfg_bias;
    logic                   res_valid;
    logic [LANES*IN_W-1:0]  res;
    logic                   res_ready;
    logic                   out_valid;
    logic [LANES*OUT_W-1:0] out_data;
    logic                   out_ready;
    logic                   busy;
    logic                   job_done;

    always #5 clk = ~clk;

    psum_accumulator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_start  (cfg_start),
        .cfg_rounds (cfg_rounds),
        .cfg_tiles  (cfg_tiles),
        .cfg_shift  (cfg_shift),
        .cfg_relu   (cfg_relu),
        .cfg_bias   (cfg_bias),
        .res_valid  (res_valid),
        .res        (res),
        .res_ready  (res_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy       (busy),
        .job_done   (job_done)
    );

    int          total = 0;
    int          bad   = 0;
    int          acc_cnt = 0;
    int          jd_cnt  = 0;
    logic [31:0] sb [$];
    logic [31:0] mon_exp;
    bit          drv_done;
    bit          run6;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [LANES*IN_W-1:0] pack4(input int a, input int b, input int c, input int d);
        return {IN_W'(d), IN_W'(c), IN_W'(b), IN_W'(a)};
    endfunction

    // Reference requantization of one lane sum.
    function automatic logic [7:0] ref_lane(input int sum, input int sh, input bit relu);
        int v;
        v = sum >>> sh;
        if (relu && v < 0) v = 0;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return 8'(v);
    endfunction

    // Monitor: compare every tile the DUT hands over, count handshakes and job_done pulses.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got %h expected none", out_data);
            end else begin
                mon_exp = sb.pop_front();
                check("out_data", 64'(out_data), 64'(mon_exp));
            end
        end
        if (rst_n && job_done) jd_cnt++;
        if (rst_n && res_valid && res_ready) acc_cnt++;
    end

    task automatic start_job(input int r, input int t, input int sh, input int rl, input int bias);
        @(posedge clk); #1;
        cfg_rounds = 8'(r);
        cfg_tiles  = 8'(t);
        cfg_shift  = 5'(sh);
        cfg_relu   = 1'(rl);
        cfg_bias   = 32'(bias);
        cfg_start  = 1'b1;
        @(posedge clk); #1;
        cfg_start  = 1'b0;
    endtask

    // Present one beat and hold it until accepted; called at posedge+1.
    task automatic send_beat(input logic [LANES*IN_W-1:0] w);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        res = w;
        res_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            done = res_ready;
            @(posedge clk); #1;
            n++;
            if (!done && n > 300) begin
                total++;
                bad++;
                $display("FAIL beat_timeout: got no res_ready expected accept within 300 cycles");
                done = 1'b1;
            end
        end
        res_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy || out_valid) && n < 2000) begin
            @(negedge clk); #1;
            n++;
        end
        check(name, 64'({busy, out_valid, 32'(sb.size())}), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int j0;
        int n;
        int beats6;
        rst_n = 1'b0;
        cfg_start = 1'b0; cfg_rounds = '0; cfg_tiles = '0; cfg_shift = '0;
        cfg_relu = 1'b0; cfg_bias = '0; res_valid = 1'b0; res = '0; out_ready = 1'b1;
        drv_done = 1'b0; run6 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'({res_ready, out_valid, busy, job_done, out_data}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: three rounds, bias 10, 5 per lane per beat -> 25; latency T+2.
        j0 = jd_cnt;
        start_job(3, 1, 0, 0, 10);
        check("t1_busy", 64'(busy), 64'd1);
        sb.push_back(32'h1919_1919);
        for (int i = 0; i < 3; i++) send_beat(pack4(5, 5, 5, 5));
        @(negedge clk);
        check("t1_valid_t1", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("t1_valid_t2", 64'(out_valid), 64'd1);
        wait_drain("t1_drain");
        check("t1_job_done", 64'(jd_cnt - j0), 64'd1);

        // 2: shift 1 with negative saturation, then ReLU.
        start_job(1, 2, 1, 0, 0);
        sb.push_back(32'h0000_3280);
        sb.push_back(32'h0000_7F80);
        send_beat(pack4(-300, 100, 0, 0));
        send_beat(pack4(-300, 300, 0, 0));
        wait_drain("t2_drain_a");
        start_job(1, 1, 1, 1, 0);
        sb.push_back(32'h7F03_0000);
        send_beat(pack4(-300, -1, 7, 1000));
        wait_drain("t2_drain_b");

        // 3: consumer stalled, six single-round tiles through a 4-deep FIFO.
        @(posedge clk); #1;
        out_ready = 1'b0;
        a0 = acc_cnt;
        start_job(1, 6, 0, 0, 0);
        for (int k = 1; k <= 6; k++)
            sb.push_back({8'(10*k+3), 8'(10*k+2), 8'(10*k+1), 8'(10*k)});
        drv_done = 1'b0;
        fork
            begin
                for (int k = 1; k <= 6; k++) send_beat(pack4(10*k, 10*k+1, 10*k+2, 10*k+3));
                drv_done = 1'b1;
            end
        join_none
        repeat (20) @(negedge clk);
        check("t3_accepted_stalled", 64'(acc_cnt - a0), 64'd4);
        check("t3_res_ready_low", 64'(res_ready), 64'd0);
        check("t3_head_held", 64'(out_data), 64'h0D0C_0B0A);
        @(posedge clk); #1;
        out_ready = 1'b1;
        n = 0;
        while (!drv_done && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("t3_driver_done", 64'(drv_done), 64'd1);
        wait_drain("t3_drain");
        check("t3_accepted_total", 64'(acc_cnt - a0), 64'd6);

        // 4: asynchronous reset mid-tile, then a clean job with zero bias.
        start_job(4, 1, 0, 0, 100);
        send_beat(pack4(1, 1, 1, 1));
        send_beat(pack4(1, 1, 1, 1));
        check("t4_busy_before", 64'({busy, res_ready}), 64'd3);
        #1;
        rst_n = 1'b0;
        #1;
        check("t4_async_reset", 64'({res_ready, out_valid, busy, job_done, out_data}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        start_job(2, 1, 0, 0, 0);
        sb.push_back(32'h2C21_160B);
        send_beat(pack4(1, 2, 3, 4));
        send_beat(pack4(10, 20, 30, 40));
        wait_drain("t4_drain");

        // 5: rounds=0 acts as 1; cfg_start while running is ignored.
        j0 = jd_cnt;
        start_job(0, 2, 0, 0, 0);
        sb.push_back(32'h0403_0201);
        sb.push_back(32'h08F9_06FB);
        send_beat(pack4(1, 2, 3, 4));
        start_job(5, 1, 3, 1, 1000);
        send_beat(pack4(-5, 6, -7, 8));
        wait_drain("t5_drain");
        check("t5_job_done", 64'(jd_cnt - j0), 64'd1);

        // 6: randomized jobs against the reference model, random gaps on both sides.
        run6 = 1'b1;
        fork
            begin
                while (run6) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        a0 = acc_cnt;
        j0 = jd_cnt;
        beats6 = 0;
        for (int j = 0; j < 20; j++) begin
            int r, re, t, sh, rl, bias;
            r    = int'($urandom_range(0, 4));
            re   = (r == 0) ? 1 : r;
            t    = int'($urandom_range(1, 3));
            sh   = int'($urandom_range(0, 4));
            rl   = int'($urandom_range(0, 1));
            bias = int'($urandom_range(0, 1000)) - 500;
            wait_idle();
            start_job(r, t, sh, rl, bias);
            for (int ti = 0; ti < t; ti++) begin
                int lv [4][4];
                int s  [4];
                logic [31:0] w;
                for (int ln = 0; ln < 4; ln++) s[ln] = bias;
                for (int b = 0; b < re; b++)
                    for (int ln = 0; ln < 4; ln++) begin
                        lv[b][ln] = int'($urandom_range(0, 4000)) - 2000;
                        s[ln] += lv[b][ln];
                    end
                for (int ln = 0; ln < 4; ln++) w[8*ln +: 8] = ref_lane(s[ln], sh, rl[0]);
                sb.push_back(w);
                for (int b = 0; b < re; b++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                    send_beat(pack4(lv[b][0], lv[b][1], lv[b][2], lv[b][3]));
                    beats6++;
                end
            end
        end
        run6 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain("t6_drain");
        check("t6_beats", 64'(acc_cnt - a0), 64'(beats6));
        check("t6_job_done", 64'(jd_cnt - j0), 64'd20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
